percept_ctrl: RTL and testbench

Sequencer for the `percept` multiply datapath, which registers `in*weight` onto a 16-bit `out` when strobed by `write`. The block:
- holds a configurable weight vector plus threshold (and optionally bias);
- accepts an N-element input vector over a valid/ready stream;
- issues one strobed multiply per element and accumulates the products;
- presents the sum and a step-activation bit on an output valid/ready stream.

It sits between the upstream sample source and the `percept` instance.

---
 rtl/percept_pkg.sv | 21 ++
 rtl/percept_ctrl_cfg.sv | 59 +++++
 rtl/percept_ctrl.sv | 116 +++++++++++
 tb/tb_percept_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/percept_pkg.sv
// Shared types and widths for the percept sequencer: FSM state encoding,
// datapath widths and the accumulator width helper.
package percept_pkg;

  localparam int PERCEPT_DW = 8;
  localparam int PERCEPT_PW = 16;

  typedef logic [2:0] state_t;

  localparam state_t RECV  = 3'd0;
  localparam state_t ISSUE = 3'd1;
  localparam state_t WAIT  = 3'd2;
  localparam state_t ACC   = 3'd3;
  localparam state_t DONE  = 3'd4;

  // Wide enough that n full-scale products can never wrap.
  function automatic int acc_width(input int n);
    return PERCEPT_PW + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/percept_ctrl_cfg.sv
// Weight/threshold/bias register file for percept_ctrl, write-gated by busy.
// The bias register exists only when PERCEPT_CTRL_BIAS_EN is defined.
module percept_ctrl_cfg
  import percept_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  localparam int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [15:0]           cfg_wdata,
  input  logic                  busy,
  input  logic [IDX_W-1:0]      idx,
  output logic [PERCEPT_DW-1:0] weight_sel,
  output logic [15:0]           threshold,
  output logic [15:0]           bias,
  output logic                  bias_load
);

  logic [PERCEPT_DW-1:0] weight [N_INPUTS];
  logic                  wr_en;

  assign wr_en      = cfg_we & ~busy;
  assign weight_sel = weight[idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      // NOTE: the weight array is reset explicitly because reset must also
      // clear configuration; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < N_INPUTS; i++) weight[i] <= '0;
      threshold <= '0;
    end else if (wr_en) begin
      if (cfg_addr < 5'(N_INPUTS))
        weight[cfg_addr[IDX_W-1:0]] <= cfg_wdata[PERCEPT_DW-1:0];
      else if (cfg_addr == 5'(N_INPUTS))
        threshold <= cfg_wdata;
    end
  end

`ifdef PERCEPT_CTRL_BIAS_EN
  logic [15:0] bias_q;

  assign bias_load = wr_en && (cfg_addr == 5'(N_INPUTS + 1));
  assign bias      = bias_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)          bias_q <= '0;
    else if (bias_load) bias_q <= cfg_wdata;
  end
`else
  assign bias_load = 1'b0;
  assign bias      = '0;
`endif

endmodule

// File: rtl/percept_ctrl.sv
// Sequencer for the external percept multiplier: streams in an N-element
// vector, issues one strobed multiply per element, accumulates and reports
// the sum plus a step activation. Optional bias via PERCEPT_CTRL_BIAS_EN.
module percept_ctrl
  import percept_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  parameter  int LAT      = 1,
  localparam int ACC_W    = acc_width(N_INPUTS)
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [15:0]           cfg_wdata,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PERCEPT_DW-1:0] in_data,
  output logic                  p_write,
  output logic [PERCEPT_DW-1:0] p_in,
  output logic [PERCEPT_DW-1:0] p_weight,
  input  logic [PERCEPT_PW-1:0] p_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_fire
);

  localparam int IDX_W = $clog2(N_INPUTS);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [ACC_W-1:0]      acc;
  logic [2:0]            cnt;
  logic [ACC_W-1:0]      sum;
  logic                  last;
  logic [PERCEPT_DW-1:0] weight_sel;
  logic [15:0]           threshold;
  logic [15:0]           bias;
  logic                  bias_load;

  percept_ctrl_cfg #(.N_INPUTS(N_INPUTS)) u_cfg (
    .clk        (clk),
    .nRst       (nRst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .busy       (busy),
    .idx        (idx),
    .weight_sel (weight_sel),
    .threshold  (threshold),
    .bias       (bias),
    .bias_load  (bias_load)
  );

  assign in_ready  = (state == RECV);
  assign p_write   = (state == ISSUE);
  assign out_valid = (state == DONE);
  assign busy      = (state != RECV) || (idx != '0);
  assign sum       = acc + ACC_W'(p_out);
  assign last      = (idx == IDX_W'(N_INPUTS - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= RECV;
      idx      <= '0;
      acc      <= '0;
      cnt      <= '0;
      p_in     <= '0;
      p_weight <= '0;
      out_sum  <= '0;
      out_fire <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          // A bias write can only land while idle, so the new value seeds acc.
          if (bias_load) acc <= ACC_W'(cfg_wdata);
          if (in_valid) begin
            p_in     <= in_data;
            p_weight <= weight_sel;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 3'(LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= ACC;
        end
        ACC: begin
          acc <= sum;
          if (last) begin
            out_sum  <= sum;
            out_fire <= (sum >= ACC_W'(threshold));
            state    <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= RECV;
          end
        end
        DONE: begin
          if (out_ready) begin
            idx   <= '0;
            acc   <= ACC_W'(bias);
            state <= RECV;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_percept_ctrl.sv
// Directed self-checking bench for percept_ctrl (N_INPUTS=4, LAT=1) with a
// behavioural percept multiplier; bias expectations follow PERCEPT_CTRL_BIAS_EN.
module tb_percept_ctrl;

  localparam int N     = 4;
  localparam int LAT   = 1;
  localparam int ACC_W = 19;

  logic             clk = 1'b0;
  logic             nRst;
  logic             cfg_we;
  logic [4:0]       cfg_addr;
  logic [15:0]      cfg_wdata;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             p_write;
  logic [7:0]       p_in;
  logic [7:0]       p_weight;
  logic [15:0]      p_out;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_fire;

  int checks = 0;
  int errors = 0;
  int pw_count = 0;
  logic [7:0] exp_w [N];

  percept_ctrl #(.N_INPUTS(N), .LAT(LAT)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .p_write   (p_write),
    .p_in      (p_in),
    .p_weight  (p_weight),
    .p_out     (p_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_fire  (out_fire)
  );

  always #5 clk = ~clk;

  // Behavioural percept: registers in*weight one edge after the write strobe.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) p_out <= '0;
    else if (p_write) p_out <= {8'h00, p_in} * {8'h00, p_weight};
  end

  always @(posedge clk) if (nRst && p_write) pw_count <= pw_count + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic configure(input logic [7:0] w0, w1, w2, w3, input logic [15:0] thr);
    cfg_write(5'd0, {8'h00, w0});
    cfg_write(5'd1, {8'h00, w1});
    cfg_write(5'd2, {8'h00, w2});
    cfg_write(5'd3, {8'h00, w3});
    cfg_write(5'd4, thr);
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Offer one element, then confirm the single ISSUE-cycle strobe and operands.
  task automatic send_elem(input string tag, input logic [7:0] d, input logic [7:0] ew);
    in_valid = 1'b1; in_data = d;
    wait_ready(tag);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_pwrite_hi"}, 32'(p_write), 32'd1);
    check({tag, "_p_in"}, 32'(p_in), 32'(d));
    check({tag, "_p_weight"}, 32'(p_weight), 32'(ew));
    @(negedge clk);
    check({tag, "_pwrite_lo"}, 32'(p_write), 32'd0);
    check({tag, "_p_in_hold"}, 32'(p_in), 32'(d));
  endtask

  // Stream a full vector of identical elements; busy_k >= 0 injects a weight[0]
  // write before that element while the vector is in progress.
  task automatic run_vector(input string tag, input logic [7:0] d, input int busy_k,
                            output logic [ACC_W-1:0] sum, output logic fire);
    int pw0 = pw_count;
    for (int k = 0; k < N; k++) begin
      if (k == busy_k) begin
        wait_ready({tag, "_bw"});
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cfg_write(5'd0, 16'd3);
      end
      send_elem($sformatf("%s_e%0d", tag, k), d, exp_w[k]);
    end
    @(negedge clk);
    check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_npulses"}, 32'(pw_count - pw0), 32'(N));
    sum = out_sum; fire = out_fire;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_p_write"}, 32'(p_write), 32'd0);
    check({tag, "_p_in"}, 32'(p_in), 32'd0);
    check({tag, "_p_weight"}, 32'(p_weight), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
    check({tag, "_out_fire"}, 32'(out_fire), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ACC_W-1:0] sum;
    logic             fire;
    int               pwc;

    nRst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    nRst = 1'b1;

    // 1: 8*8 + 8*9 + 8*10 + 8*11 = 304 >= 300
    configure(8'd8, 8'd9, 8'd10, 8'd11, 16'd300);
    run_vector("s1", 8'd8, -1, sum, fire);
    check("s1_sum", 32'(sum), 32'd304);
    check("s1_fire", 32'(fire), 32'd1);

    // 2: threshold just above the sum
    cfg_write(5'd4, 16'd305);
    run_vector("s2", 8'd8, -1, sum, fire);
    check("s2_sum", 32'(sum), 32'd304);
    check("s2_fire", 32'(fire), 32'd0);
    cfg_write(5'd4, 16'd300);

    // 4: back-pressure in DONE with a pending input element
    for (int k = 0; k < N; k++) send_elem($sformatf("s4_e%0d", k), 8'd8, exp_w[k]);
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = 8'd8;
    pwc = pw_count;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("s4_hold_valid", 32'(out_valid), 32'd1);
      check("s4_hold_sum", 32'(out_sum), 32'd304);
      check("s4_hold_fire", 32'(out_fire), 32'd1);
      check("s4_hold_ready", 32'(in_ready), 32'd0);
    end
    check("s4_no_pwrite", 32'(pw_count - pwc), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("s4_released", 32'(in_ready), 32'd1);
    run_vector("s4b", 8'd8, -1, sum, fire);
    check("s4b_sum", 32'(sum), 32'd304);

    // 5: weight write while busy is dropped; the same write while idle lands
    run_vector("s5a", 8'd8, 1, sum, fire);
    check("s5a_sum", 32'(sum), 32'd304);
    run_vector("s5b", 8'd8, -1, sum, fire);
    check("s5b_sum", 32'(sum), 32'd304);
    cfg_write(5'd0, 16'd3);
    exp_w[0] = 8'd3;
    run_vector("s5c", 8'd8, -1, sum, fire);
    check("s5c_sum", 32'(sum), 32'd264);
    check("s5c_fire", 32'(fire), 32'd0);

    // 3: full-scale products, 4 * 65025 = 260100 with no wrap
    configure(8'd255, 8'd255, 8'd255, 8'd255, 16'd65535);
    run_vector("s3", 8'd255, -1, sum, fire);
    check("s3_sum", 32'(sum), 32'd260100);
    check("s3_fire", 32'(fire), 32'd1);

    // Out-of-range address is ignored
    cfg_write(5'd20, 16'd7);
    run_vector("s3b", 8'd255, -1, sum, fire);
    check("s3b_sum", 32'(sum), 32'd260100);

    // 6: reset mid-vector clears everything, including configuration
    configure(8'd8, 8'd9, 8'd10, 8'd11, 16'd300);
    send_elem("s6_e0", 8'd8, 8'd8);
    send_elem("s6_e1", 8'd8, 8'd9);
    nRst = 1'b0;
    #2;
    check_reset_vals("s6_rst");
    @(negedge clk);
    nRst = 1'b1;
    exp_w[0] = 8'd0; exp_w[1] = 8'd0; exp_w[2] = 8'd0; exp_w[3] = 8'd0;
    run_vector("s6z", 8'd8, -1, sum, fire);
    check("s6z_sum", 32'(sum), 32'd0);
    check("s6z_fire", 32'(fire), 32'd1);
    configure(8'd8, 8'd9, 8'd10, 8'd11, 16'd300);
`ifdef PERCEPT_CTRL_BIAS_EN
    cfg_write(5'd5, 16'd100);
    run_vector("s6", 8'd8, -1, sum, fire);
    check("s6_sum", 32'(sum), 32'd404);
    run_vector("s6r", 8'd8, -1, sum, fire);
    check("s6r_sum", 32'(sum), 32'd404);
`else
    cfg_write(5'd5, 16'd100);
    run_vector("s6", 8'd8, -1, sum, fire);
    check("s6_sum", 32'(sum), 32'd304);
`endif
    check("s6_fire", 32'(fire), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
